fetch_stage_r32i: RTL and testbench

FETCH_STAGE_R32I -- requirements
Module: fetch_stage_r32i

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 78 +++++++
 rtl/fetch_stage_r32i.sv | 138 +++++++++++++
 tb/tb_fetch_stage_r32i.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the RV32I fetch stage: FSM state encoding, the
// instruction-buffer entry layout and the default reset PC.
package fetch_pkg;

   localparam int unsigned    XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] ins;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small instruction FIFO between fetch and decode. The head entry is kept in
// its own register so the decoder sees a flop output, not a read mux.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   input  logic   flush,
   output logic   full,
   output logic   empty,
   output entry_t head
);

   localparam int unsigned PW = $clog2(DEPTH);

   entry_t        mem_q [DEPTH];
   entry_t        head_q, head_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = head_q;
   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Next pointers, occupancy and head value.
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + PW'(1);
         if (pop_ok)  rd_d = rd_q + PW'(1);
         if (push_ok && !pop_ok)      cnt_d = cnt_q + (PW+1)'(1);
         else if (pop_ok && !push_ok) cnt_d = cnt_q - (PW+1)'(1);
         // New data becomes the head when it lands in an empty (or emptying) buffer.
         if (push_ok && ((cnt_q == '0) || ((cnt_q == (PW+1)'(1)) && pop_ok)))
            head_d = push_data;
         else if (pop_ok)
            head_d = mem_q[rd_q + PW'(1)];
      end
   end

   // Control state and head register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   // Storage array; contents are don't-care while their slot is unoccupied.
   always_ff @(posedge clock) begin
      if (push_ok && !flush) mem_q[wr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_stage_r32i.sv
// RV32I instruction fetch stage: single-outstanding memory requester feeding a
// small instruction buffer, with redirect/flush handling.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-target trap).
module fetch_stage_r32i
   import fetch_pkg::*;
#(
   parameter int unsigned      dataW     = 32,
   parameter logic [dataW-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned      BUF_DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   output logic             imem_req,
   output logic [dataW-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [dataW-1:0] imem_rdata,
   input  logic             redirect,
   input  logic [dataW-1:0] redirect_target,
   output logic             ins_valid,
   output logic [dataW-1:0] ins_out,
   output logic [dataW-1:0] ins_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic             fetch_misaligned,
`endif
   input  logic             ins_ready
);

   typedef struct packed {
      logic [dataW-1:0] ins;
      logic [dataW-1:0] pc;
   } entry_t;

   fetch_state_t     state_q, state_d;
   logic [dataW-1:0] pc_q, pc_d;
   logic [dataW-1:0] raddr_q, raddr_d;   // address of the request in flight
   logic             run_q, run_d;       // low out of reset and while trapped
   logic             trap_d;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic             trap_q;
`endif

   logic             buf_push, buf_full, buf_empty;
   entry_t           buf_wdata, buf_head;
   logic [dataW-1:0] target_al;
   logic             outstanding;

   // PC is always word aligned; low target bits never reach the address bus.
   assign target_al = redirect_target & ~dataW'(3);

   // A response is still owed if we are waiting on one that has not arrived,
   // or a request is being accepted in this very cycle.
   assign outstanding = (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid) ||
                        ((state_q == FETCH) && imem_req && imem_ready);

   // Request is a pure decode of registered state, so it stays stable until accepted.
   assign imem_req  = (state_q == FETCH) && !buf_full && run_q;
   assign imem_addr = pc_q;

   assign buf_wdata = '{ins: imem_rdata, pc: raddr_q};
   assign ins_valid = !buf_empty;
   assign ins_out   = buf_head.ins;
   assign ins_pc    = buf_head.pc;

   // Next-state logic: redirect overrides every other event.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      raddr_d  = raddr_q;
      buf_push = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_d = trap_q;
      if (redirect) trap_d = |redirect_target[1:0];
`else
      trap_d = 1'b0;
`endif
      if (redirect) begin
         pc_d    = target_al;
         state_d = outstanding ? DRAIN : FETCH;
      end else begin
         case (state_q)
            FETCH: if (imem_req && imem_ready) begin
               pc_d    = pc_q + dataW'(4);
               raddr_d = pc_q;
               state_d = WAIT;
            end
            WAIT: if (imem_rvalid) begin
               buf_push = 1'b1;
               state_d  = FETCH;
            end
            DRAIN: if (imem_rvalid) state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end
      run_d = !trap_d;
   end

   // FSM and fetch-side registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         raddr_q <= RESET_PC;
         run_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         raddr_q <= raddr_d;
         run_q   <= run_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q  <= trap_d;
`endif
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch_misaligned = trap_q;
`endif

   fetch_buffer #(
      .DEPTH   (BUF_DEPTH),
      .entry_t (entry_t)
   ) u_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (buf_push),
      .push_data (buf_wdata),
      .pop       (ins_valid && ins_ready),
      .flush     (redirect),
      .full      (buf_full),
      .empty     (buf_empty),
      .head      (buf_head)
   );

endmodule

// File: tb/tb_fetch_stage_r32i.sv
// Directed bench for fetch_stage_r32i with a scoreboard of expected {ins, pc}.
module tb_fetch_stage_r32i;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        ins_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;

   fetch_stage_r32i dut (
      .clock           (clock),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .ins_valid       (ins_valid),
      .ins_out         (ins_out),
      .ins_pc          (ins_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
      .fetch_misaligned(fetch_misaligned),
`endif
      .ins_ready       (ins_ready)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Retire the head against the scoreboard if it is consumed this cycle, then advance.
   task automatic tick();
      sb_t e;
      if (ins_valid && ins_ready) begin
         if (sb.size() == 0) chk("sb_underflow_ins_valid", 32'(ins_valid), 32'd0);
         else begin
            e = sb.pop_front();
            chk("sb_ins", ins_out, e.ins);
            chk("sb_pc", ins_pc, e.pc);
         end
      end
      @(posedge clock); #1;
   endtask

   // Wait for a request at exp_addr, accept it, return data one cycle later.
   task automatic fetch_one(input logic [31:0] data, input logic [31:0] exp_addr);
      int n = 0;
      while (!imem_req && n < 20) begin tick(); n++; end
      chk("req_seen", 32'(imem_req), 32'd1);
      chk("req_addr", imem_addr, exp_addr);
      imem_ready = 1'b1; tick(); imem_ready = 1'b0;
      chk("req_low_in_wait", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = data;
      sb.push_back('{data, exp_addr});
      tick();
      imem_rvalid = 1'b0;
      chk("ins_valid_after_rvalid", 32'(ins_valid), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_target = '0; ins_ready = 1'b0;
      sb.delete();
      tick(); tick();
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins_out", ins_out, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // Basic stream from reset: addresses 0,4,8, first instruction visible one cycle after rvalid
      ins_ready = 1'b1;
      fetch_one(32'h00500093, 32'h0);
      chk("first_ins_out", ins_out, 32'h00500093);
      chk("first_ins_pc", ins_pc, 32'h0);
      fetch_one(32'h00a00113, 32'h4);
      fetch_one(32'h00f00193, 32'h8);

      // Accept a request, then reset before the response; stray rvalid afterwards is ignored
      chk("addr_before_rst", imem_addr, 32'hC);
      imem_ready = 1'b1; tick(); imem_ready = 1'b0;
      do_reset();
      imem_rvalid = 1'b1; imem_rdata = 32'hBADBAD00; tick(); imem_rvalid = 1'b0;
      chk("stray_rvalid_ignored", 32'(ins_valid), 32'd0);

      // Backpressure: buffer fills to 2, request drops, head holds steady
      ins_ready = 1'b0;
      fetch_one(32'h11111111, 32'h0);
      fetch_one(32'h22222222, 32'h4);
      imem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("full_req_low", 32'(imem_req), 32'd0);
         chk("hold_ins_out", ins_out, 32'h11111111);
         chk("hold_ins_pc", ins_pc, 32'h0);
         tick();
      end
      imem_ready = 1'b0;
      ins_ready = 1'b1; tick(); tick(); ins_ready = 1'b0;
      chk("drained_empty", 32'(ins_valid), 32'd0);

      // Redirect while waiting: drain the late response, resume at target
      chk("addr_pre_wait", imem_addr, 32'h8);
      imem_ready = 1'b1; tick(); imem_ready = 1'b0;
      redirect = 1'b1; redirect_target = 32'h100; sb.delete(); tick(); redirect = 1'b0;
      chk("drain_req_low", 32'(imem_req), 32'd0);
      tick(); tick();
      chk("drain_req_still_low", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; tick(); imem_rvalid = 1'b0;
      chk("drain_no_stale", 32'(ins_valid), 32'd0);
      chk("drain_resume_req", 32'(imem_req), 32'd1);
      chk("drain_resume_addr", imem_addr, 32'h100);
      ins_ready = 1'b1;
      fetch_one(32'h33333333, 32'h100);
      tick();
      ins_ready = 1'b0;

      // Redirect coincident with rvalid, buffer holding an entry: all dropped
      fetch_one(32'h44444444, 32'h104);
      imem_ready = 1'b1; tick(); imem_ready = 1'b0;
      redirect = 1'b1; redirect_target = 32'h300;
      imem_rvalid = 1'b1; imem_rdata = 32'h55555555; sb.delete();
      tick();
      redirect = 1'b0; imem_rvalid = 1'b0;
      chk("coinc_flush", 32'(ins_valid), 32'd0);
      chk("coinc_req", 32'(imem_req), 32'd1);
      chk("coinc_addr", imem_addr, 32'h300);
      ins_ready = 1'b1;
      fetch_one(32'h66666666, 32'h300);
      tick();

      // PC wrap at the top of the address space
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; sb.delete(); tick(); redirect = 1'b0;
      chk("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
      fetch_one(32'h77777777, 32'hFFFF_FFFC);
      chk("wrap_next_addr", imem_addr, 32'h0);
      tick();

      // Redirect in the acceptance cycle, then a second redirect while draining
      imem_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h40; sb.delete();
      tick();
      imem_ready = 1'b0;
      chk("acc_redir_drain", 32'(imem_req), 32'd0);
      redirect_target = 32'h80; tick(); redirect = 1'b0;
      chk("redir_in_drain_req", 32'(imem_req), 32'd0);
      chk("redir_in_drain_pc", imem_addr, 32'h80);
      imem_rvalid = 1'b1; imem_rdata = 32'hCAFE0000; tick(); imem_rvalid = 1'b0;
      chk("after_drain_req", 32'(imem_req), 32'd1);
      chk("after_drain_addr", imem_addr, 32'h80);
      fetch_one(32'h88888888, 32'h80);
      tick();

      // Misaligned redirect target
      redirect = 1'b1; redirect_target = 32'h102; sb.delete(); tick(); redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_flag_set", 32'(fetch_misaligned), 32'd1);
      chk("mis_req_low", 32'(imem_req), 32'd0);
      tick(); tick();
      chk("mis_req_stays_low", 32'(imem_req), 32'd0);
      redirect = 1'b1; redirect_target = 32'h200; tick(); redirect = 1'b0;
      chk("mis_flag_clear", 32'(fetch_misaligned), 32'd0);
      fetch_one(32'h99999999, 32'h200);
`else
      chk("mis_forced_align", imem_addr, 32'h100);
      fetch_one(32'h99999999, 32'h100);
`endif
      tick();
      chk("final_empty", 32'(ins_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
